reg_chain_alu: RTL and testbench
================================

# reg_chain_alu

Parametrised successor to the two-register datapath: a DEPTH-stage sample delay chain with a wrapping sample counter, feeding a registered, mode-selectable arithmetic unit that combines the newest and oldest samples. It sits between an input sample source and downstream logic that consumes `out`. It adds generic width and depth, input qualification, flush, four operating modes, saturation flagging and output valid tracking.

## Interface
- WIDTH, 8, sample and result width in bits (≥2)
- DEPTH, 4, number of chain stages (≥2)
- CW, 4, sample counter width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  input sample
- in_vld  input  1  sample qualifier; chain shifts only when high
- flush  input  1  synchronous clear of chain, valids and counter
- mode  input  2  00 sat-add, 01 floor-sub, 10 max, 11 average
- R1  output  WIDTH  stage 0 (newest sample)
- R2  output  WIDTH  stage DEPTH-1 (oldest sample)
- q  output  CW  count of accepted samples, mod 2^CW
- out  output  WIDTH  registered result
- out_vld  output  1  out computed from a full chain
- sat  output  1  out was clamped this cycle

## Operation
- Chain: registers s[0..DEPTH-1], each with a valid bit v[k]. R1=s[0], R2=s[DEPTH-1].
- Accept, when in_vld=1 and flush=0: s[0]<=in, v[0]<=1, s[k]<=s[k-1], v[k]<=v[k-1], q<=q+1.
  - q wraps from 2^CW-1 to 0 silently.
- in_vld=0 and flush=0: chain, valids and q hold.
- flush=1: all s, v and q go to 0 on the edge. flush takes priority over in_vld, so that sample is dropped. out, out_vld and sat go to 0 on the same edge.
- full = v[DEPTH-1]. Every stage is valid whenever the oldest stage is valid.
- Result stage: registered every cycle, evaluated on current R1 (a), R2 (b) and mode.
  - 00: a+b computed at WIDTH+1 bits. If the carry is set, out=2^WIDTH-1 and sat=1.
  - 01: a-b. If b>a, out=0 and sat=1.
  - 10: max(a,b), unsigned; sat=0.
  - 11: (a+b)>>1 computed at WIDTH+1 bits, no precision loss from overflow; sat=0.
- out_vld <= full, except flush forces 0. sat is only meaningful when out_vld=1; it is computed regardless.
- Unsigned arithmetic throughout.
- Mode changes take effect on the next edge. No pipeline drain is needed.

## Timing
- Reset (async assert, any time): s, v, q, out, out_vld, sat all 0 immediately, with no clock required. Release is synchronous to the next clk edge. The first accept can happen on the first edge where rst=0.
- Reset asserted mid-stream discards all samples. The first post-reset accept restarts q at 1.
- Sample latency: a sample accepted at edge t appears on R1 after edge t. It appears on R2 after DEPTH-1 further accepts, not cycles.
- Result latency: out reflects the R1/R2/mode values present between edges t and t+1, and appears after edge t+1 (1 cycle).
- out_vld first rises one edge after the DEPTH-th accept following reset or flush.
- Simultaneous flush and in_vld: flush wins. q=0, chain is empty.
- Counter wrap and accept on the same edge: q=0 and the sample is still stored.

## Test plan
- Fill and add (WIDTH=8, DEPTH=4, mode 00): after reset, accept 11,22,33,44 on consecutive edges -> R1=44, R2=11, q=4. Next edge: out=55, out_vld=1, sat=0. Continuing with 55..99 -> out sequence 77,99,121,143,165 (result lags the chain by one edge), q=9.
- Saturation and floor (DEPTH=2): accept 200 then 100.
  - mode 00 -> out=255, sat=1.
  - Then accept 11, 44 with mode 01 (R1=44, R2=11) -> out=33, sat=0.
  - Accept 11 again (R1=11, R2=44) -> out=0, sat=1.
- Max and average (DEPTH=2): accept 255, 255.
  - mode 11 -> out=255, sat=0.
  - Accept 3 (R1=3, R2=255) with mode 10 -> out=255.
  - Switch to mode 11 -> out=129.
- Gating and wrap: toggle in_vld every other cycle for 16 accepts -> chain moves only on qualified edges, and q steps 1..15 then returns to 0.
- Flush: with the chain full, assert flush together with in_vld=1 and in=77 -> next edge: q=0, R1=R2=0, out_vld=0, out=0, and 77 is not stored.
- Async reset mid-stream: assert rst between edges with the chain full -> all outputs 0 before the next clk edge. After release, accept 5 -> R1=5, q=1, out_vld stays 0 until DEPTH accepts.

Source files
------------

// File: rtl/reg_chain_alu.sv
// Sample delay chain with wrapping accept counter, feeding a registered
// mode-selectable unit that combines the newest and oldest samples.
module reg_chain_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  input  logic             flush,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [CW-1:0]    q,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             sat
);

  localparam logic [1:0] ModeSatAdd = 2'b00;
  localparam logic [1:0] ModeSubFlr = 2'b01;
  localparam logic [1:0] ModeMax    = 2'b10;
  localparam logic [1:0] ModeAvg    = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] s_q;
  logic [DEPTH-1:0]            v_q;
  logic [CW-1:0]               cnt_q;
  logic [WIDTH-1:0]            out_q;
  logic                        out_vld_q;
  logic                        sat_q;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             sat_d;

  // Valid bits shift alongside the data, so v_q[DEPTH-1] marks a full chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      v_q   <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      s_q   <= '0;
      v_q   <= '0;
      cnt_q <= '0;
    end else if (in_vld) begin
      s_q   <= {s_q[DEPTH-2:0], in};
      v_q   <= {v_q[DEPTH-2:0], 1'b1};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign a   = s_q[0];
  assign b   = s_q[DEPTH-1];
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    unique case (mode)
      ModeSatAdd: begin
        if (sum[WIDTH]) begin
          res_d = '1;
          sat_d = 1'b1;
        end else begin
          res_d = sum[WIDTH-1:0];
        end
      end
      ModeSubFlr: begin
        if (b > a) begin
          res_d = '0;
          sat_d = 1'b1;
        end else begin
          res_d = a - b;
        end
      end
      ModeMax: res_d = (a > b) ? a : b;
      ModeAvg: res_d = sum[WIDTH:1];
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if (flush) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      out_q     <= res_d;
      out_vld_q <= v_q[DEPTH-1];
      sat_q     <= sat_d;
    end
  end

  assign R1      = s_q[0];
  assign R2      = s_q[DEPTH-1];
  assign q       = cnt_q;
  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_reg_chain_alu.sv
// Directed bench: DEPTH=4 and DEPTH=2 instances share stimulus; each check
// targets one instance.
module tb_reg_chain_alu;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       in_vld;
  logic       flush;
  logic [1:0] mode;

  logic [7:0] r1_a, r2_a, out_a, r1_b, r2_b, out_b;
  logic [3:0] q_a, q_b;
  logic       ov_a, sat_a, ov_b, sat_b;

  int ncmp  = 0;
  int nfail = 0;

  reg_chain_alu #(.WIDTH(8), .DEPTH(4), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .flush(flush), .mode(mode),
    .R1(r1_a), .R2(r2_a), .q(q_a), .out(out_a), .out_vld(ov_a), .sat(sat_a)
  );

  reg_chain_alu #(.WIDTH(8), .DEPTH(2), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .flush(flush), .mode(mode),
    .R1(r1_b), .R2(r2_b), .q(q_b), .out(out_b), .out_vld(ov_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    bit         sel;
    logic [7:0] din;
    bit         vld;
    bit         fl;
    logic [1:0] md;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [3:0] q;
    logic [7:0] o;
    bit         ov;
    bit         st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rb, bit sel, int din, bit vld, bit fl, int md,
                              int r1, int r2, int q, int o, bit ov, bit st);
    vec_t v;
    v.rst_before = rb;  v.sel = sel;  v.din = 8'(din); v.vld = vld; v.fl = fl;
    v.md = 2'(md);      v.r1 = 8'(r1); v.r2 = 8'(r2);   v.q = 4'(q);
    v.o = 8'(o);        v.ov = ov;     v.st = st;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, bit sel, int r1, int r2, int q, int o, bit ov, bit st);
    chk({tag, ".R1"},      sel ? int'(r1_b)  : int'(r1_a),  r1);
    chk({tag, ".R2"},      sel ? int'(r2_b)  : int'(r2_a),  r2);
    chk({tag, ".q"},       sel ? int'(q_b)   : int'(q_a),   q);
    chk({tag, ".out"},     sel ? int'(out_b) : int'(out_a), o);
    chk({tag, ".out_vld"}, sel ? int'(ov_b)  : int'(ov_a),  int'(ov));
    chk({tag, ".sat"},     sel ? int'(sat_b) : int'(sat_a), int'(st));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in = '0; in_vld = 1'b0; flush = 1'b0; mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic drive_edge(int din, bit vld, bit fl, int md);
    @(negedge clk);
    in = 8'(din); in_vld = vld; flush = fl; mode = 2'(md);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         cnt;
    logic [7:0] hist[$];
    logic [7:0] e1, e2;

    rst = 1'b1; in = '0; in_vld = 1'b0; flush = 1'b0; mode = 2'b00;
    #1;
    check_all("async_rst0_a", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    check_all("async_rst0_b", 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);

    // Fill and add, DEPTH=4: result lags the chain by one edge.
    vecs.push_back(mk(1, 0, 11, 1, 0, 0, 11,  0, 1,   0, 0, 0));
    vecs.push_back(mk(0, 0, 22, 1, 0, 0, 22,  0, 2,  11, 0, 0));
    vecs.push_back(mk(0, 0, 33, 1, 0, 0, 33,  0, 3,  22, 0, 0));
    vecs.push_back(mk(0, 0, 44, 1, 0, 0, 44, 11, 4,  33, 0, 0));
    vecs.push_back(mk(0, 0, 55, 1, 0, 0, 55, 22, 5,  55, 1, 0));
    vecs.push_back(mk(0, 0, 66, 1, 0, 0, 66, 33, 6,  77, 1, 0));
    vecs.push_back(mk(0, 0, 77, 1, 0, 0, 77, 44, 7,  99, 1, 0));
    vecs.push_back(mk(0, 0, 88, 1, 0, 0, 88, 55, 8, 121, 1, 0));
    vecs.push_back(mk(0, 0, 99, 1, 0, 0, 99, 66, 9, 143, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 99, 66, 9, 165, 1, 0));
    // Saturating add and floor subtract, DEPTH=2.
    vecs.push_back(mk(1, 1, 200, 1, 0, 0, 200,   0, 1,   0, 0, 0));
    vecs.push_back(mk(0, 1, 100, 1, 0, 0, 100, 200, 2, 200, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0, 0, 100, 200, 2, 255, 1, 1));
    vecs.push_back(mk(0, 1,  11, 1, 0, 1,  11, 100, 3,   0, 1, 1));
    vecs.push_back(mk(0, 1,  44, 1, 0, 1,  44,  11, 4,   0, 1, 1));
    vecs.push_back(mk(0, 1,   0, 0, 0, 1,  44,  11, 4,  33, 1, 0));
    vecs.push_back(mk(0, 1,  11, 1, 0, 1,  11,  44, 5,  33, 1, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0, 1,  11,  44, 5,   0, 1, 1));
    // Max and average, DEPTH=2.
    vecs.push_back(mk(1, 1, 255, 1, 0, 3, 255,   0, 1,   0, 0, 0));
    vecs.push_back(mk(0, 1, 255, 1, 0, 3, 255, 255, 2, 127, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0, 3, 255, 255, 2, 255, 1, 0));
    vecs.push_back(mk(0, 1,   3, 1, 0, 2,   3, 255, 3, 255, 1, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0, 2,   3, 255, 3, 255, 1, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0, 3,   3, 255, 3, 129, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      drive_edge(vecs[i].din, vecs[i].vld, vecs[i].fl, vecs[i].md);
      check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].q,
                vecs[i].o, vecs[i].ov, vecs[i].st);
    end

    // Gating and counter wrap, DEPTH=4.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 34; i++) begin
      bit vld;
      vld = (i % 2 == 0);
      drive_edge(i + 1, vld, 1'b0, 0);
      if (vld) begin
        cnt = (cnt + 1) % 16;
        hist.push_front(8'(i + 1));
      end
      e1 = (hist.size() > 0) ? hist[0] : 8'd0;
      e2 = (hist.size() > 3) ? hist[3] : 8'd0;
      chk($sformatf("gate%0d.q", i), int'(q_a), cnt);
      chk($sformatf("gate%0d.R1", i), int'(r1_a), int'(e1));
      chk($sformatf("gate%0d.R2", i), int'(r2_a), int'(e2));
    end

    // Flush wins over a simultaneous accept.
    do_reset();
    for (int i = 1; i <= 4; i++) drive_edge(i, 1'b1, 1'b0, 0);
    drive_edge(0, 1'b0, 1'b0, 0);
    check_all("pre_flush", 1'b0, 4, 1, 4, 5, 1'b1, 1'b0);
    drive_edge(77, 1'b1, 1'b1, 0);
    check_all("flush", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("flush.b.q", int'(q_b), 0);
    drive_edge(0, 1'b0, 1'b0, 0);
    check_all("post_flush", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Async reset between edges, then restart.
    do_reset();
    for (int i = 1; i <= 4; i++) drive_edge(i, 1'b1, 1'b0, 0);
    drive_edge(0, 1'b0, 1'b0, 0);
    check_all("pre_rst", 1'b0, 4, 1, 4, 5, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    drive_edge(5, 1'b1, 1'b0, 0);
    check_all("rst_acc1", 1'b0, 5, 0, 1, 0, 1'b0, 1'b0);
    drive_edge(6, 1'b1, 1'b0, 0);
    drive_edge(7, 1'b1, 1'b0, 0);
    drive_edge(8, 1'b1, 1'b0, 0);
    check_all("rst_acc4", 1'b0, 8, 5, 4, 7, 1'b0, 1'b0);
    drive_edge(0, 1'b0, 1'b0, 0);
    check_all("rst_full", 1'b0, 8, 5, 4, 13, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
